// File: rtl/psum_pkg.sv
// Shared definitions for the column partial-sum drain and the PE array top.
package psum_pkg;

   localparam int PSUM_AK_BW  = 20;
   localparam int PSUM_OUT_BW = 24;
   localparam int PSUM_DEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: wide accumulator plus narrower addend, clamps to all-ones.
module sat_add_u #(
   parameter int A_BW = 24,
   parameter int B_BW = 20
) (
   input  logic [A_BW-1:0] a,
   input  logic [B_BW-1:0] b,
   output logic [A_BW-1:0] sum,
   output logic            sat
);

   logic [A_BW:0] full;

   assign full = {1'b0, a} + (A_BW+1)'(b);
   assign sat  = full[A_BW];
   assign sum  = sat ? '1 : full[A_BW-1:0];

endmodule

// File: rtl/psum_drain_acc.sv
// Per-column partial-sum accumulator: sums kernel passes into a small buffer,
// then drains the finished words over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; ovf and last results remain visible
// ACCUM | writing/accumulating in_psum into buf_q, one entry per in_valid
// DRAIN | presenting buf_q[rd_idx] on out_data until every entry is accepted
module psum_drain_acc
   import psum_pkg::*;
#(
   parameter int AK_BW   = PSUM_AK_BW,
   parameter int OUT_BW  = PSUM_OUT_BW,
   parameter int DEPTH   = PSUM_DEPTH,
   parameter int IDX_BW  = 4,
   parameter int PASS_BW = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PASS_BW-1:0] num_pass,
   input  logic [IDX_BW:0]    num_out,
   input  logic               in_valid,
   input  logic [AK_BW-1:0]   in_psum,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [OUT_BW-1:0]  out_data,
   output logic               busy,
   output logic               done,
   output logic               ovf
);

   localparam logic [IDX_BW-1:0]  IDX_ONE  = 1;
   localparam logic [IDX_BW:0]    NO_ONE   = 1;
   localparam logic [IDX_BW:0]    DEPTH_W  = (IDX_BW+1)'(DEPTH);
   localparam logic [PASS_BW-1:0] PASS_ONE = 1;

   state_t             state;
   logic [IDX_BW-1:0]  wr_idx;
   logic [IDX_BW-1:0]  rd_idx;
   logic [IDX_BW-1:0]  rd_nxt;
   logic [PASS_BW-1:0] pass_cnt;
   logic [PASS_BW-1:0] np_q;
   logic [IDX_BW:0]    no_q;
   logic [OUT_BW-1:0]  buf_q [DEPTH];

   logic [PASS_BW-1:0] num_pass_eff;
   logic [IDX_BW:0]    num_out_eff;
   logic               wr_en;
   logic               wr_last;
   logic               rd_last;
   logic               pass_last;
   logic               wr_sat;
   logic               add_sat;
   logic [OUT_BW-1:0]  add_sum;
   logic [OUT_BW-1:0]  wr_data;

   always_comb begin
      num_pass_eff = num_pass;
      if (num_pass == '0) num_pass_eff = PASS_ONE;
      num_out_eff = num_out;
      if (num_out == '0)          num_out_eff = NO_ONE;
      else if (num_out > DEPTH_W) num_out_eff = DEPTH_W;
   end

   sat_add_u #(.A_BW(OUT_BW), .B_BW(AK_BW)) u_sat_add (
      .a   (buf_q[wr_idx]),
      .b   (in_psum),
      .sum (add_sum),
      .sat (add_sat)
   );

   // First pass overwrites, so stale contents from earlier tiles never leak in.
   assign wr_data   = (pass_cnt == '0) ? OUT_BW'(in_psum) : add_sum;
   assign wr_sat    = (pass_cnt != '0) && add_sat;
   assign wr_en     = (state == ACCUM) && in_valid;
   assign wr_last   = ({1'b0, wr_idx} == (no_q - NO_ONE));
   assign rd_last   = ({1'b0, rd_idx} == (no_q - NO_ONE));
   assign pass_last = (pass_cnt == (np_q - PASS_ONE));
   assign rd_nxt    = rd_idx + IDX_ONE;

   always_ff @(posedge clk) begin
      if (wr_en) buf_q[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_idx    <= '0;
         rd_idx    <= '0;
         pass_cnt  <= '0;
         np_q      <= PASS_ONE;
         no_q      <= NO_ONE;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  busy     <= 1'b1;
                  np_q     <= num_pass_eff;
                  no_q     <= num_out_eff;
                  wr_idx   <= '0;
                  rd_idx   <= '0;
                  pass_cnt <= '0;
                  ovf      <= 1'b0;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  if (wr_sat) ovf <= 1'b1;
                  if (wr_last) begin
                     wr_idx   <= '0;
                     pass_cnt <= pass_cnt + PASS_ONE;
                     if (pass_last) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        // Entry 0 is being written this very cycle when num_out is 1.
                        out_data  <= (wr_idx == '0) ? wr_data : buf_q[0];
                     end
                  end else begin
                     wr_idx <= wr_idx + IDX_ONE;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (rd_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     rd_idx   <= rd_nxt;
                     out_data <= buf_q[rd_nxt];
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_drain_acc.sv
// Randomized bench for psum_drain_acc against a pass-by-pass arithmetic model.
module tb_psum_drain_acc;
   import psum_pkg::*;

   localparam int AK_BW   = PSUM_AK_BW;
   localparam int OUT_BW  = PSUM_OUT_BW;
   localparam int DEPTH   = PSUM_DEPTH;
   localparam int IDX_BW  = 4;
   localparam int PASS_BW = 5;
   localparam longint OMAX = (64'sd1 << OUT_BW) - 1;

   logic               clk;
   logic               rst;
   logic               start;
   logic [PASS_BW-1:0] num_pass;
   logic [IDX_BW:0]    num_out;
   logic               in_valid;
   logic [AK_BW-1:0]   in_psum;
   logic               out_ready;
   logic               out_valid;
   logic [OUT_BW-1:0]  out_data;
   logic               busy;
   logic               done;
   logic               ovf;

   int n_tests;
   int n_fail;
   longint stim_q[$];

   psum_drain_acc #(
      .AK_BW(AK_BW), .OUT_BW(OUT_BW), .DEPTH(DEPTH), .IDX_BW(IDX_BW), .PASS_BW(PASS_BW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_pass  (num_pass),
      .num_out   (num_out),
      .in_valid  (in_valid),
      .in_psum   (in_psum),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit rdy_pick(input int mode, input int cyc);
      bit r;
      r = 1'b1;
      if (mode == 1) r = bit'($urandom_range(0, 1));
      else if (mode == 2) begin
         case (cyc % 6)
            0, 2, 3: r = 1'b0;
            default: r = 1'b1;
         endcase
      end
      return r;
   endfunction

   // Caller sits at a negedge; returns at a negedge. abort_k>=0 resets after that many handshakes.
   task automatic run_tile(input int np, input int no, input int stall_pct,
                           input int rdy_mode, input int abort_k);
      int     np_e, no_e, k, cyc, total;
      longint acc[DEPTH];
      longint s;
      bit     exp_ovf, rdy;
      np_e = (np == 0) ? 1 : np;
      no_e = (no == 0) ? 1 : ((no > DEPTH) ? DEPTH : no);
      total = np_e * no_e;
      while (stim_q.size() < total) stim_q.push_back(longint'($urandom_range(0, (1 << AK_BW) - 1)));

      exp_ovf = 1'b0;
      for (int p = 0; p < np_e; p++) begin
         for (int i = 0; i < no_e; i++) begin
            if (p == 0) acc[i] = stim_q[p*no_e + i];
            else begin
               s = acc[i] + stim_q[p*no_e + i];
               if (s > OMAX) begin
                  s = OMAX;
                  exp_ovf = 1'b1;
               end
               acc[i] = s;
            end
         end
      end

      start    = 1'b1;
      num_pass = PASS_BW'(np);
      num_out  = (IDX_BW+1)'(no);
      @(negedge clk);
      start = 1'b0;
      chk("busy_start", busy, 1);
      chk("ovf_clr", ovf, 0);
      chk("done_once", done, 0);

      for (int j = 0; j < total; j++) begin
         while ($urandom_range(0, 99) < stall_pct) begin
            in_valid = 1'b0;
            in_psum  = AK_BW'($urandom);
            start    = 1'($urandom_range(0, 1));
            num_pass = PASS_BW'($urandom);
            num_out  = (IDX_BW+1)'($urandom);
            @(negedge clk);
            chk("ov_stall", out_valid, 0);
         end
         start    = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         in_psum  = AK_BW'(stim_q[j]);
         @(negedge clk);
         if (j < total - 1) chk("ov_accum", out_valid, 0);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("ov_latency", out_valid, 1);

      k   = 0;
      cyc = 0;
      while (k < no_e && cyc < 400) begin
         chk("done_early", done, 0);
         chk("ov_drain", out_valid, 1);
         chk($sformatf("data%0d", k), out_data, 64'(acc[k]));
         rdy       = rdy_pick(rdy_mode, cyc);
         out_ready = rdy;
         in_valid  = 1'($urandom_range(0, 1));
         in_psum   = AK_BW'($urandom);
         start     = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
         if (rdy) k++;
         if (abort_k >= 0 && k == abort_k) break;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      if (cyc >= 400) chk("drain_timeout", 0, 1);

      if (abort_k >= 0) begin
         rst = 1'b1;
         #1;
         chk("rst_ov", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_data", out_data, 0);
         @(negedge clk);
         rst = 1'b0;
         chk("rst_done1", done, 0);
         @(negedge clk);
         chk("rst_done2", done, 0);
      end else begin
         chk("done_pulse", done, 1);
         chk("ov_after", out_valid, 0);
         chk("busy_after", busy, 0);
         chk("ovf", ovf, 64'(exp_ovf));
      end
      stim_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      num_pass  = '0;
      num_out   = '0;
      in_valid  = 1'b0;
      in_psum   = '0;
      out_ready = 1'b0;
      #2;
      chk("reset_ov", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_data", out_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_psum  = AK_BW'($urandom);
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_ov", out_valid, 0);
      end
      in_valid = 1'b0;

      stim_q = '{10, 20, 30, 40};
      run_tile(1, 4, 0, 0, -1);

      stim_q = '{5, 7, 1, 2, 100, 200};
      run_tile(3, 2, 40, 0, -1);

      stim_q = '{20'hFFFFF, 20'hFFFFF};
      run_tile(2, 1, 0, 0, -1);

      for (int i = 0; i < 17; i++) stim_q.push_back(20'hFFFFF);
      run_tile(17, 1, 10, 0, -1);

      stim_q = '{111, 222, 333};
      run_tile(1, 3, 0, 2, -1);

      run_tile(0, 0, 20, 1, -1);
      run_tile(2, 20, 20, 1, -1);

      stim_q = '{1, 2, 3, 4, 5, 6, 7, 8};
      run_tile(2, 4, 0, 0, 1);
      run_tile(1, 4, 0, 0, -1);

      for (int t = 0; t < 6; t++)
         run_tile($urandom_range(0, 4), $urandom_range(0, 20), 30, 1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_drain_acc.md
Name: psum_drain_acc

Overview:
- Sits directly downstream of the bottom PE of one systolic-array column.
- Consumes that PE's registered partial sum (o_acc_kernel stream) and accumulates it across multiple kernel passes into a small per-output buffer.
- Drains the finished sums to the output writer over a valid/ready handshake.
- One instance per array column.

Parameters:
- AK_BW, 20, width of incoming PE partial sum (unsigned).
- OUT_BW, 24, width of accumulated output word (unsigned, must be >= AK_BW).
- DEPTH, 16, number of output entries buffered per tile.
- IDX_BW, 4, index width, equal to clog2(DEPTH).
- PASS_BW, 4, width of the pass-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  one-cycle pulse; begins a tile; honoured only in IDLE.
- num_pass  in  PASS_BW  passes to accumulate; sampled on start; 0 treated as 1.
- num_out  in  IDX_BW+1  entries per pass; sampled on start; 0 treated as 1; values >DEPTH clamp to DEPTH.
- in_valid  in  1  in_psum is valid this cycle.
- in_psum  in  AK_BW  partial sum from column's last PE.
- out_ready  in  1  downstream accepts out_data.
- out_valid  out  1  out_data holds a finished sum.
- out_data  out  OUT_BW  accumulated result.
- busy  out  1  high in ACCUM or DRAIN.
- done  out  1  one-cycle pulse after the last drain handshake.
- ovf  out  1  sticky saturation flag; cleared on start.

Behaviour:
- Reset (async, rst=1) → state IDLE; wr_idx, rd_idx, pass_cnt = 0; out_valid, busy, done, ovf = 0; out_data = 0. Buffer contents are not reset; pass 0 overwrites them.
- FSM IDLE:
  - start=1 → ACCUM next cycle.
  - Latch num_pass and num_out with the 0/clamp rules above.
  - Clear ovf and all counters.
- FSM ACCUM:
  - Each cycle with in_valid=1, entry buf[wr_idx] is written.
  - pass_cnt==0: buf ← zero-extended in_psum (overwrite).
  - Otherwise: buf ← sat_add(buf, in_psum), unsigned; on saturation, result = 2^OUT_BW-1 and ovf←1.
  - wr_idx increments. At num_out-1 it wraps to 0 and pass_cnt increments.
  - Write of entry num_out-1 in pass num_pass-1 → DRAIN next cycle.
  - in_valid=0 cycles are stalls; no state change.
- FSM DRAIN:
  - out_valid=1, out_data = buf[rd_idx]. out_data is held stable while out_valid && !out_ready.
  - Each handshake increments rd_idx.
  - Handshake on rd_idx==num_out-1 → IDLE; done=1 for exactly that next cycle; out_valid=0 the same cycle.
- Latency: out_valid rises 1 cycle after the final accepted in_valid. Back-to-back drain at 1 word/cycle with out_ready held high.
- in_valid outside ACCUM is ignored (no write, no flag).
- start outside IDLE is ignored.
- start in the same cycle as done is honoured, since the state is IDLE then.
- busy = (state != IDLE).
- Reset asserted mid-ACCUM or mid-DRAIN aborts immediately to the reset values; no done pulse.
- ovf stays valid through DRAIN and IDLE until the next start.

Decomposition:
- Shared package psum_pkg holds:
  - state enum IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2;
  - default AK_BW, OUT_BW, DEPTH constants shared with the PE array top.
- One sub-module: sat_add_u (unsigned saturating adder, OUT_BW + AK_BW → OUT_BW, outputs sum and sat flag). Purely combinational, reusable by other column drains.
- Buffer is a register array inside psum_drain_acc, not a separate RAM.

Test Plan:
- Single pass: rst, start with num_pass=1, num_out=4; in_psum 10,20,30,40 on consecutive valids; out_ready=1 → out_data 10,20,30,40 on 4 consecutive cycles starting 1 cycle after the last input; done pulses once; ovf=0.
- Multi-pass with stalls: num_pass=3, num_out=2; inputs 5,7 | 1,2 (with 2 idle cycles) | 100,200 → drain 106,209.
- Saturation: OUT_BW=24, num_pass=2, num_out=1; inputs 0xFFFFF, then repeat with a buffer preloaded near max via 17 passes of 0xFFFFF → out_data=0xFFFFFF, ovf=1. ovf clears on the next start.
- Backpressure: num_out=3, drain with out_ready toggling 0,1,0,0,1,1 → out_data stable while stalled; exactly 3 handshakes, in order; done after the third.
- Ignored inputs and edge fields: start during ACCUM and in_valid during IDLE/DRAIN → no effect; num_pass=0 and num_out=0 behave as 1; num_out=20 clamps to 16.
- Reset mid-operation: assert rst during DRAIN after 1 handshake → out_valid=0, busy=0, no done. A new tile afterward produces correct fresh results, with no stale data from earlier passes.
